// File: rtl/br_pkg.sv
// Shared constants, state encoding and round-robin search helper for the
// four-channel FIFO read arbiter.
package br_pkg;

    localparam int BR_NCH   = 4;
    localparam int BR_DEPTH = 2;
    localparam int BR_CNTW  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FLUSH = 2'd2
    } br_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } br_pick_t;

    // Search from+1, from+2, from+3 and finally from itself (modulo 4).
    function automatic br_pick_t br_pick_next(input logic [1:0]        from,
                                              input logic [BR_NCH-1:0] nonempty);
        br_pick_t   p;
        logic [1:0] c;
        p.found = 1'b0;
        p.idx   = from;
        for (int i = 1; i <= BR_NCH; i++) begin
            c = from + 2'(i);
            if (!p.found && nonempty[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/br_skid2.sv
// Two-entry tagged output buffer; order preserving, simultaneous push and pop
// leave the occupancy unchanged.
module br_skid2
    import br_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 2
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               in_vld,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [TAGW-1:0]    in_tag,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAGW-1:0]    out_tag,
    output logic [BR_CNTW-1:0] count
);

    logic [WIDTH-1:0] data_q [BR_DEPTH];
    logic [TAGW-1:0]  tag_q  [BR_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign out_vld  = (count != '0);
    assign out_data = data_q[rd_ptr];
    assign out_tag  = tag_q[rd_ptr];
    assign pop      = out_vld && out_rdy;
    assign push     = in_vld && ((count != BR_CNTW'(BR_DEPTH)) || pop);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < BR_DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= in_data;
                tag_q[wr_ptr]  <= in_tag;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/br_rdarb4x32.sv
// Round-robin burst arbiter merging four FIFO read ports into one stream,
// with a two-entry output buffer and a registered fill-level sum.
module br_rdarb4x32
    import br_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PTR   = 2,
    parameter int BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        enable,
    input  logic [BR_NCH-1:0]           rdempty,
    input  logic [BR_NCH*(PTR+1)-1:0]   rdusedw,
    input  logic [BR_NCH*WIDTH-1:0]     q,
    output logic [BR_NCH-1:0]           rdreq,
    output logic [WIDTH-1:0]            dout,
    output logic [1:0]                  dout_src,
    output logic                        dout_vld,
    input  logic                        dout_rdy,
    output logic [1:0]                  grant,
    output logic                        busy,
    output logic [PTR+2:0]              total_used
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    br_state_e        state;
    br_state_e        state_nx;
    logic [1:0]       grant_nx;
    logic [1:0]       last_grant;
    logic [1:0]       last_grant_nx;
    logic [3:0]       burst_cnt;
    logic [3:0]       burst_nx;
    logic             inflight;
    logic [1:0]       inflight_tag;
    logic             issue;
    logic             pop;
    logic             room;
    logic [2:0]       occ_eff;
    logic [BR_CNTW-1:0] buf_count;
    logic [PTR+2:0]   used_sum;
    br_pick_t         pick_rot;
    br_pick_t         pick_idle;

    assign pick_rot  = br_pick_next(grant, ~rdempty);
    assign pick_idle = br_pick_next(last_grant, ~rdempty);

    // A word leaving the buffer this cycle frees its slot for a new read,
    // which is what allows one word per cycle with dout_rdy held high.
    assign pop     = dout_vld && dout_rdy;
    assign occ_eff = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign room    = (occ_eff < 3'd2);

    assign rdreq = issue ? (4'b0001 << grant) : 4'b0000;
    assign busy  = (state != IDLE) || (buf_count != '0);

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        burst_nx      = burst_cnt;
        issue         = 1'b0;
        case (state)
            IDLE: begin
                if (enable && pick_idle.found) begin
                    state_nx = SERVE;
                    grant_nx = pick_idle.idx;
                    burst_nx = '0;
                end
            end
            SERVE: begin
                if (!enable) begin
                    state_nx = FLUSH;
                end else if ((burst_cnt == BURST_L) || rdempty[grant]) begin
                    if (pick_rot.found) begin
                        grant_nx = pick_rot.idx;
                        burst_nx = '0;
                    end else if (!inflight) begin
                        state_nx      = IDLE;
                        last_grant_nx = grant;
                    end
                end else if (room) begin
                    issue    = 1'b1;
                    burst_nx = burst_cnt + 4'd1;
                end
            end
            FLUSH: begin
                if (!inflight) begin
                    state_nx      = IDLE;
                    last_grant_nx = grant;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        used_sum = '0;
        for (int n = 0; n < BR_NCH; n++) begin
            used_sum = used_sum + {2'b00, rdusedw[n*(PTR+1) +: PTR+1]};
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state        <= IDLE;
            grant        <= 2'd0;
            last_grant   <= 2'd3;
            burst_cnt    <= '0;
            inflight     <= 1'b0;
            inflight_tag <= 2'd0;
            total_used   <= '0;
        end else begin
            state        <= state_nx;
            grant        <= grant_nx;
            last_grant   <= last_grant_nx;
            burst_cnt    <= burst_nx;
            inflight     <= issue;
            inflight_tag <= grant;
            total_used   <= used_sum;
        end
    end

    br_skid2 #(
        .WIDTH (WIDTH),
        .TAGW  (2)
    ) u_skid (
        .clk      (clk),
        .reset_   (reset_),
        .in_vld   (inflight),
        .in_data  (q[inflight_tag*WIDTH +: WIDTH]),
        .in_tag   (inflight_tag),
        .out_vld  (dout_vld),
        .out_rdy  (dout_rdy),
        .out_data (dout),
        .out_tag  (dout_src),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_br_rdarb4x32.sv
// Directed bench for br_rdarb4x32: behavioural FIFOs on the four read ports,
// per-scenario tasks with hand-computed expectations.
module tb_br_rdarb4x32;

    logic         clk;
    logic         reset_;
    logic         enable;
    logic [3:0]   rdempty;
    logic [11:0]  rdusedw;
    logic [127:0] q;
    logic [3:0]   rdreq;
    logic [31:0]  dout;
    logic [1:0]   dout_src;
    logic         dout_vld;
    logic         dout_rdy;
    logic [1:0]   grant;
    logic         busy;
    logic [4:0]   total_used;

    int vectors;
    int miscompares;

    logic [31:0] f0[$];
    logic [31:0] f1[$];
    logic [31:0] f2[$];
    logic [31:0] f3[$];
    logic [31:0] qreg [4];
    logic [1:0]  got_src[$];
    logic [31:0] got_data[$];
    int          pulses [4];
    int          multi_req;

    br_rdarb4x32 #(
        .WIDTH (32),
        .PTR   (2),
        .BURST (2)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .enable     (enable),
        .rdempty    (rdempty),
        .rdusedw    (rdusedw),
        .q          (q),
        .rdreq      (rdreq),
        .dout       (dout),
        .dout_src   (dout_src),
        .dout_vld   (dout_vld),
        .dout_rdy   (dout_rdy),
        .grant      (grant),
        .busy       (busy),
        .total_used (total_used)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mkword(input int ch, input int k);
        return 32'hD000_0000 | (32'(ch) << 8) | 32'(k);
    endfunction

    function automatic int fsize(input int ch);
        case (ch)
            0:       return f0.size();
            1:       return f1.size();
            2:       return f2.size();
            default: return f3.size();
        endcase
    endfunction

    task automatic fifo_sync();
        for (int n = 0; n < 4; n++) begin
            rdempty[n]          = (fsize(n) == 0);
            rdusedw[n*3 +: 3]   = 3'(fsize(n));
            q[n*32 +: 32]       = qreg[n];
        end
    endtask

    task automatic fifo_load(input int ch, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            case (ch)
                0:       f0.push_back(mkword(ch, k));
                1:       f1.push_back(mkword(ch, k));
                2:       f2.push_back(mkword(ch, k));
                default: f3.push_back(mkword(ch, k));
            endcase
        end
    endtask

    task automatic fifo_clear();
        f0.delete();
        f1.delete();
        f2.delete();
        f3.delete();
        fifo_sync();
    endtask

    task automatic fifo_pop(input int ch);
        case (ch)
            0:       if (f0.size() > 0) qreg[0] = f0.pop_front();
            1:       if (f1.size() > 0) qreg[1] = f1.pop_front();
            2:       if (f2.size() > 0) qreg[2] = f2.pop_front();
            default: if (f3.size() > 0) qreg[3] = f3.pop_front();
        endcase
    endtask

    task automatic clear_log();
        got_src.delete();
        got_data.delete();
        for (int n = 0; n < 4; n++) pulses[n] = 0;
    endtask

    // One clock: observe at the falling edge, update the FIFO models just after the rising edge.
    task automatic step();
        logic [3:0] rd_s;
        @(negedge clk);
        if (dout_vld && dout_rdy) begin
            got_src.push_back(dout_src);
            got_data.push_back(dout);
        end
        for (int n = 0; n < 4; n++) if (rdreq[n]) pulses[n]++;
        if ($countones(rdreq) > 1) multi_req++;
        rd_s = rdreq;
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) if (rd_s[n]) fifo_pop(n);
        fifo_sync();
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        enable = 1'b1;
        fifo_load(2, 3);
        fifo_sync();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (rdreq !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_rdreq: got %b need 0000", rdreq); end
        vectors++; if (dout_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dout_vld: got %b need 0", dout_vld); end
        vectors++; if (dout !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_dout: got %h need 0", dout); end
        vectors++; if (dout_src !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_dout_src: got %0d need 0", dout_src); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b need 0", busy); end
        vectors++; if (grant !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_grant: got %0d need 0", grant); end
        vectors++; if (total_used !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_total_used: got %0d need 0", total_used); end
        fifo_clear();
        enable = 1'b0;
        reset_ = 1'b1;
        clear_log();
        repeat (2) step();
    endtask

    task automatic test_single_channel();
        clear_log();
        fifo_clear();
        fifo_load(0, 3);
        fifo_sync();
        enable   = 1'b1;
        dout_rdy = 1'b1;
        repeat (20) step();
        vectors++; if (pulses[0] !== 3) begin miscompares++; $display("[TB] FAIL single_rdreq0: got %0d pulses need 3", pulses[0]); end
        vectors++; if (pulses[1] + pulses[2] + pulses[3] !== 0) begin miscompares++; $display("[TB] FAIL single_other_rdreq: got %0d pulses need 0", pulses[1] + pulses[2] + pulses[3]); end
        vectors++; if (got_data.size() !== 3) begin miscompares++; $display("[TB] FAIL single_count: got %0d words need 3", got_data.size()); end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= got_data.size() || got_data[k] !== mkword(0, k) || got_src[k] !== 2'd0) begin
                miscompares++;
                $display("[TB] FAIL single_word%0d: got src=%0d data=%h need src=0 data=%h", k, (k < got_src.size()) ? got_src[k] : 2'd0, (k < got_data.size()) ? got_data[k] : 32'h0, mkword(0, k));
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle_busy: got %b need 0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_src [16];
        int exp_k   [16];
        exp_src = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
        exp_k   = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3, 2, 3};
        fifo_clear();
        do_reset();
        for (int n = 0; n < 4; n++) fifo_load(n, 4);
        fifo_sync();
        enable   = 1'b1;
        dout_rdy = 1'b1;
        repeat (60) step();
        vectors++; if (got_data.size() !== 16) begin miscompares++; $display("[TB] FAIL rr_count: got %0d words need 16", got_data.size()); end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (k >= got_data.size() || got_src[k] !== 2'(exp_src[k]) || got_data[k] !== mkword(exp_src[k], exp_k[k])) begin
                miscompares++;
                $display("[TB] FAIL rr_word%0d: got src=%0d data=%h need src=%0d data=%h", k, (k < got_src.size()) ? got_src[k] : 2'd0, (k < got_data.size()) ? got_data[k] : 32'h0, exp_src[k], mkword(exp_src[k], exp_k[k]));
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_idle_busy: got %b need 0", busy); end
    endtask

    task automatic test_backpressure();
        clear_log();
        fifo_clear();
        fifo_load(1, 4);
        fifo_sync();
        enable   = 1'b1;
        dout_rdy = 1'b0;
        repeat (5) step();
        vectors++; if (dout_vld !== 1'b1 || dout !== mkword(1, 0) || dout_src !== 2'd1) begin miscompares++; $display("[TB] FAIL bp_hold_early: got vld=%b src=%0d data=%h need vld=1 src=1 data=%h", dout_vld, dout_src, dout, mkword(1, 0)); end
        repeat (5) step();
        vectors++; if (pulses[1] !== 2) begin miscompares++; $display("[TB] FAIL bp_rdreq: got %0d pulses need 2", pulses[1]); end
        vectors++; if (dout_vld !== 1'b1 || dout !== mkword(1, 0) || dout_src !== 2'd1) begin miscompares++; $display("[TB] FAIL bp_hold_late: got vld=%b src=%0d data=%h need vld=1 src=1 data=%h", dout_vld, dout_src, dout, mkword(1, 0)); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_busy: got %b need 1", busy); end
        dout_rdy = 1'b1;
        repeat (20) step();
        vectors++; if (got_data.size() !== 4) begin miscompares++; $display("[TB] FAIL bp_count: got %0d words need 4", got_data.size()); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= got_data.size() || got_data[k] !== mkword(1, k) || got_src[k] !== 2'd1) begin
                miscompares++;
                $display("[TB] FAIL bp_word%0d: got src=%0d data=%h need src=1 data=%h", k, (k < got_src.size()) ? got_src[k] : 2'd0, (k < got_data.size()) ? got_data[k] : 32'h0, mkword(1, k));
            end
        end
    endtask

    task automatic test_flush();
        int cyc;
        fifo_clear();
        do_reset();
        fifo_load(2, 4);
        fifo_sync();
        enable   = 1'b1;
        dout_rdy = 1'b1;
        cyc = 0;
        while (pulses[2] < 2 && cyc < 12) begin
            step();
            cyc++;
        end
        vectors++; if (pulses[2] !== 2) begin miscompares++; $display("[TB] FAIL flush_reach_second_rdreq: got %0d pulses need 2 within 12 cycles", pulses[2]); end
        enable = 1'b0;
        #1;
        vectors++; if (rdreq !== 4'b0000 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_stop: got rdreq=%b busy=%b need rdreq=0000 busy=1", rdreq, busy); end
        repeat (10) step();
        vectors++; if (pulses[2] !== 2) begin miscompares++; $display("[TB] FAIL flush_no_more_rdreq: got %0d pulses need 2", pulses[2]); end
        vectors++; if (got_data.size() !== 2 || got_data[0] !== mkword(2, 0) || got_data[1] !== mkword(2, 1)) begin miscompares++; $display("[TB] FAIL flush_words: got %0d words need 2 (%h,%h)", got_data.size(), mkword(2, 0), mkword(2, 1)); end
        vectors++; if (busy !== 1'b0 || fsize(2) !== 2) begin miscompares++; $display("[TB] FAIL flush_idle: got busy=%b left=%0d need busy=0 left=2", busy, fsize(2)); end
    endtask

    task automatic test_reset_midburst();
        int exp_src [6];
        int exp_k   [6];
        exp_src = '{1, 1, 2, 2, 3, 3};
        exp_k   = '{0, 1, 0, 1, 2, 3};
        clear_log();
        fifo_clear();
        fifo_load(3, 4);
        fifo_sync();
        enable   = 1'b1;
        dout_rdy = 1'b0;
        repeat (8) step();
        vectors++; if (dout_vld !== 1'b1 || grant !== 2'd3 || pulses[3] !== 2) begin miscompares++; $display("[TB] FAIL midrst_setup: got vld=%b grant=%0d pulses=%0d need vld=1 grant=3 pulses=2", dout_vld, grant, pulses[3]); end
        fifo_load(1, 2);
        fifo_load(2, 2);
        fifo_sync();
        reset_ = 1'b0;
        #1;
        vectors++; if (rdreq !== 4'b0 || dout_vld !== 1'b0 || dout !== 32'h0 || dout_src !== 2'd0) begin miscompares++; $display("[TB] FAIL midrst_outputs: got rdreq=%b vld=%b src=%0d data=%h need all 0", rdreq, dout_vld, dout_src, dout); end
        vectors++; if (busy !== 1'b0 || grant !== 2'd0 || total_used !== 5'd0) begin miscompares++; $display("[TB] FAIL midrst_status: got busy=%b grant=%0d used=%0d need 0/0/0", busy, grant, total_used); end
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        clear_log();
        dout_rdy = 1'b1;
        step();
        vectors++; if (grant !== 2'd1) begin miscompares++; $display("[TB] FAIL midrst_first_grant: got %0d need 1", grant); end
        repeat (30) step();
        vectors++; if (got_data.size() !== 6) begin miscompares++; $display("[TB] FAIL midrst_count: got %0d words need 6", got_data.size()); end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (k >= got_data.size() || got_src[k] !== 2'(exp_src[k]) || got_data[k] !== mkword(exp_src[k], exp_k[k])) begin
                miscompares++;
                $display("[TB] FAIL midrst_word%0d: got src=%0d data=%h need src=%0d data=%h", k, (k < got_src.size()) ? got_src[k] : 2'd0, (k < got_data.size()) ? got_data[k] : 32'h0, exp_src[k], mkword(exp_src[k], exp_k[k]));
            end
        end
    endtask

    task automatic test_total_used();
        clear_log();
        enable = 1'b0;
        fifo_clear();
        step();
        fifo_load(0, 3);
        fifo_load(1, 1);
        fifo_load(3, 4);
        fifo_sync();
        vectors++; if (total_used !== 5'd0) begin miscompares++; $display("[TB] FAIL used_before: got %0d need 0", total_used); end
        step();
        vectors++; if (total_used !== 5'd8) begin miscompares++; $display("[TB] FAIL used_3104: got %0d need 8", total_used); end
        fifo_clear();
        for (int n = 0; n < 4; n++) fifo_load(n, 4);
        fifo_sync();
        step();
        vectors++; if (total_used !== 5'd16) begin miscompares++; $display("[TB] FAIL used_full: got %0d need 16", total_used); end
        vectors++; if (pulses[0] + pulses[1] + pulses[2] + pulses[3] !== 0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL used_disabled: got pulses=%0d busy=%b need 0/0", pulses[0] + pulses[1] + pulses[2] + pulses[3], busy); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        multi_req   = 0;
        reset_      = 1'b1;
        enable      = 1'b0;
        dout_rdy    = 1'b1;
        rdempty     = 4'hF;
        rdusedw     = '0;
        q           = '0;
        for (int n = 0; n < 4; n++) qreg[n] = 32'h0;
        clear_log();
        fifo_sync();
        #2;
        reset_ = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_midburst();
        test_total_used();
        vectors++; if (multi_req !== 0) begin miscompares++; $display("[TB] FAIL rdreq_onehot: got %0d cycles with >1 rdreq need 0", multi_req); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/br_rdarb4x32.md
BR_RDARB4X32 -- requirements
Module: br_rdarb4x32

Interface
REQ-001 Parameter WIDTH, default 32, data width of each FIFO read port.
REQ-002 Parameter PTR, default 2, so each FIFO rdusedw is PTR+1 bits.
REQ-003 Parameter BURST, default 4, maximum consecutive words taken from one channel before the grant rotates (range 1..15).
REQ-004 clk  in  1  single clock; all four FIFO read sides run on this clock.
REQ-005 reset_  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high allows new FIFO reads to be issued.
REQ-007 rdempty  in  4  per-channel FIFO empty flag; bit n is channel n.
REQ-008 rdusedw  in  4*(PTR+1)  per-channel fill level, channel n at bits [n*(PTR+1) +: PTR+1], used for status only.
REQ-009 q  in  4*WIDTH  per-channel FIFO read data, channel n at bits [n*WIDTH +: WIDTH], valid 1 cycle after that channel's rdreq.
REQ-010 rdreq  out  4  per-channel FIFO read request, at most one bit high per cycle.
REQ-011 dout  out  WIDTH  merged output data.
REQ-012 dout_src  out  2  channel index of dout.
REQ-013 dout_vld  out  1  dout/dout_src valid.
REQ-014 dout_rdy  in  1  downstream accepts; a word transfers on any cycle with dout_vld&&dout_rdy.
REQ-015 grant  out  2  currently granted channel.
REQ-016 busy  out  1  high in any state other than IDLE, or while buffer occupancy > 0.
REQ-017 total_used  out  PTR+3  sum of the four rdusedw values, registered.

Function
REQ-018 Three states: IDLE, SERVE, FLUSH.
REQ-019 IDLE->SERVE when enable=1 and any rdempty bit=0; grant loads the first non-empty channel searching upward (modulo 4) from last_grant+1.
REQ-020 In SERVE, rdreq[grant] is asserted iff rdempty[grant]=0, enable=1, and (buffer occupancy + in-flight reads) < 2.
REQ-021 The 2-entry output buffer captures q[grant of the issuing cycle] 1 cycle after each rdreq, tagged with that channel index; FIFO order is preserved.
REQ-022 The burst counter increments on each rdreq and clears on grant change.
REQ-023 Rotation from SERVE: when the burst counter reaches BURST, or rdempty[grant]=1, grant moves to the next non-empty channel above the current one (modulo 4) on the following cycle; no rdreq is issued in that switch cycle.
REQ-024 If no channel is non-empty at rotation, the block returns to IDLE once in-flight reads are zero; last_grant keeps the final grant.
REQ-025 A single non-empty channel is regranted to itself after BURST words, with the counter cleared.
REQ-026 SERVE->FLUSH when enable falls; FLUSH issues no rdreq and goes to IDLE once in-flight reads are zero. Buffered words still drain to dout.
REQ-027 dout_vld is high whenever buffer occupancy > 0; dout/dout_src show the oldest entry and hold stable while dout_vld=1 and dout_rdy=0.
REQ-028 A simultaneous buffer capture and output transfer leaves occupancy unchanged; occupancy never exceeds 2 and no word is dropped or duplicated.
REQ-029 Peak throughput is 1 word/cycle with dout_rdy held high, excluding switch cycles.
REQ-030 An rdempty bit rising in the same cycle as its rdreq is not possible by FIFO contract; any such occurrence is ignored.

Reset
REQ-031 While reset_=0: state=IDLE, grant=0, last_grant=3, burst counter=0, occupancy=0, in-flight=0, rdreq=0, dout_vld=0, dout=0, dout_src=0, busy=0, total_used=0.
REQ-032 Reset assertion mid-burst discards buffered and in-flight words; the first grant after release goes to the lowest non-empty channel.

Structure
REQ-033 State encodings, the channel count (4) and the buffer depth (2) are kept in a shared br_pkg constants file.
REQ-034 The 2-entry output buffer is a single sub-module, br_skid2, with ports clk, reset_, in_vld, in_data, in_tag, out_vld, out_rdy, out_data, out_tag and count.

Verification
REQ-035 Ch0 only has 3 words A0..A2, dout_rdy=1, enable=1 -> rdreq[0] pulses 3 times, dout outputs A0,A1,A2 with dout_src=0, then IDLE with busy=0.
REQ-036 All channels full (4 words each), BURST=2 -> dout_src sequence 0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3 with 16 words in order.
REQ-037 Ch1 has 4 words, dout_rdy=0 for 10 cycles -> exactly 2 rdreq pulses, dout_vld=1 and dout stable; after dout_rdy rises all 4 words are delivered.
REQ-038 enable falls after the second rdreq of a 4-word burst -> no further rdreq, 2 words delivered, FLUSH then IDLE.
REQ-039 reset_ pulsed low for 1 cycle while occupancy=2 -> all outputs reach reset values immediately; after release the first grant goes to the lowest non-empty channel.
REQ-040 rdusedw values 3,1,0,4 -> total_used=8 one cycle later.
